pixel_scheduler: RTL and testbench

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

---
 rtl/pixel_scheduler.sv | 141 ++++++++++++++
 tb/tb_pixel_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
// Frame sequencer for a WS2811 string: steps ledindex through the string, captures each
// pixel's colour from the ledcontroller, hands it to the serializer and times the latch gap.
module pixel_scheduler #(
    parameter int PIXEL_CYCLES = 64,
    parameter int LATCH_CYCLES = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  numleds,
    output logic [7:0]  ledindex,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        PRESENT = 2'd2,
        LATCH   = 2'd3
    } state_t;

    localparam int MAX_CYCLES = (PIXEL_CYCLES > LATCH_CYCLES) ? PIXEL_CYCLES : LATCH_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] PIX_LAST   = CW'(PIXEL_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    // A one-cycle latch gap must raise frame_done on entry to LATCH.
    localparam logic LATCH_SHORT = (LATCH_CYCLES == 1) ? 1'b1 : 1'b0;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    nleds_r;

    logic [CW-1:0] cnt_next_s;
    logic          last_pixel_s;
    logic          handshake_s;

    // Next-count, end-of-string and transfer decode.
    always_comb begin
        cnt_next_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        last_pixel_s = 1'b0;
        handshake_s  = 1'b0;
        if (ledindex == (nleds_r - 8'd1)) begin
            last_pixel_s = 1'b1;
        end else begin
            last_pixel_s = 1'b0;
        end
        if (pix_valid && pix_ready) begin
            handshake_s = 1'b1;
        end else begin
            handshake_s = 1'b0;
        end
    end

    // Frame state machine with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            nleds_r    <= 8'd0;
            ledindex   <= 8'd0;
            pix_data   <= 24'd0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_done <= 1'b0;
                    pix_valid  <= 1'b0;
                    if (start) begin
                        nleds_r  <= numleds;
                        ledindex <= 8'd0;
                        cnt_r    <= {CW{1'b0}};
                        busy     <= 1'b1;
                        if (numleds == 8'd0) begin
                            state_r    <= LATCH;
                            frame_done <= LATCH_SHORT;
                        end else begin
                            state_r <= COMPUTE;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                COMPUTE: begin
                    frame_done <= 1'b0;
                    if (cnt_r == PIX_LAST) begin
                        pix_data  <= {green, red, blue};
                        pix_valid <= 1'b1;
                        state_r   <= PRESENT;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                PRESENT: begin
                    frame_done <= 1'b0;
                    if (handshake_s) begin
                        pix_valid <= 1'b0;
                        cnt_r     <= {CW{1'b0}};
                        if (last_pixel_s) begin
                            state_r    <= LATCH;
                            frame_done <= LATCH_SHORT;
                        end else begin
                            ledindex <= ledindex + 8'd1;
                            state_r  <= COMPUTE;
                        end
                    end else begin
                        pix_valid <= 1'b1;
                    end
                end
                LATCH: begin
                    // frame_done marks the final LATCH cycle, so a start beside it is still ignored.
                    if (cnt_r == LATCH_LAST) begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        cnt_r      <= cnt_next_s;
                        frame_done <= (cnt_next_s == LATCH_LAST);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= {CW{1'b0}};
                    ledindex   <= 8'd0;
                    pix_valid  <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: timing, backpressure, empty/max strings, ignored start, reset abort.
module tb_pixel_scheduler;

    localparam int LC = 3000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  numleds;
    logic [7:0]  ledindex;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;

    int n_total = 0;
    int n_pass  = 0;

    int         xfers    = 0;
    int         fd_count = 0;
    int         seq_err  = 0;
    logic [7:0] last_idx = 8'd0;

    pixel_scheduler #(.PIXEL_CYCLES(64), .LATCH_CYCLES(LC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .numleds    (numleds),
        .ledindex   (ledindex),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer / pulse monitor: counts handshakes and frame_done cycles, checks index stepping.
    always @(posedge clk) begin
        if (frame_done) fd_count <= fd_count + 1;
        if (pix_valid && pix_ready) begin
            xfers    <= xfers + 1;
            last_idx <= ledindex;
            if (ledindex != 8'd0 && ledindex != last_idx + 8'd1) seq_err <= seq_err + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = pix_valid, 1 = frame_done; n = ticks until seen (== limit on timeout)
    task automatic wait_sig(input int which, input int limit, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            seen = (which == 0) ? pix_valid : frame_done;
        end
    endtask

    task automatic pulse_start(input logic [7:0] leds);
        numleds = leds;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pix_ready = 1'b1; numleds = 8'd5;
        tick();
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (pix_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", pix_valid); else n_pass++;
        n_total++; if (ledindex !== 8'd0) $display("FAIL reset_idx got %0d want 0", ledindex); else n_pass++;
        n_total++; if (pix_data !== 24'd0) $display("FAIL reset_data got %h want 0", pix_data); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %0b want 0", frame_done); else n_pass++;
        rst = 1'b0; start = 1'b0; pix_ready = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        int n;
        int fd0;
        red = 8'h11; green = 8'h22; blue = 8'h33; pix_ready = 1'b1;
        pulse_start(8'd3);
        for (int p = 0; p < 3; p++) begin
            wait_sig(0, 200, n);
            n_total++; if (n !== (p == 0 ? 64 : 65)) $display("FAIL basic_lat%0d got %0d want %0d", p, n, (p == 0 ? 64 : 65)); else n_pass++;
            n_total++; if (pix_data !== 24'h221133) $display("FAIL basic_data%0d got %h want 221133", p, pix_data); else n_pass++;
            n_total++; if (ledindex !== p[7:0]) $display("FAIL basic_idx got %0d want %0d", ledindex, p); else n_pass++;
        end
        fd0 = fd_count;
        wait_sig(1, LC + 100, n);
        n_total++; if (n !== LC) $display("FAIL basic_latch got %0d want %0d", n, LC); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_fd got %0b want 1", busy); else n_pass++;
        // start alongside frame_done must be dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL fd_start_ignored got busy %0b want 0", busy); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL fd_start_still_idle got busy %0b want 0", busy); else n_pass++;
        n_total++; if (fd_count - fd0 !== 1) $display("FAIL basic_fd_once got %0d want 1", fd_count - fd0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n;
        int x0;
        logic stable;
        red = 8'hA1; green = 8'hB2; blue = 8'hC3; pix_ready = 1'b0;
        pulse_start(8'd2);
        wait_sig(0, 200, n);
        n_total++; if (pix_data !== 24'hB2A1C3) $display("FAIL bp_order got %h want b2a1c3", pix_data); else n_pass++;
        red = 8'h44; green = 8'h55; blue = 8'h66;
        stable = 1'b1;
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pix_valid !== 1'b1 || pix_data !== 24'hB2A1C3 || ledindex !== 8'd0) stable = 1'b0;
        end
        n_total++; if (stable !== 1'b1) $display("FAIL bp_stable got %0b want 1", stable); else n_pass++;
        n_total++; if (xfers - x0 !== 0) $display("FAIL bp_no_xfer got %0d want 0", xfers - x0); else n_pass++;
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        tick();
        n_total++; if (xfers - x0 !== 1) $display("FAIL bp_one_xfer got %0d want 1", xfers - x0); else n_pass++;
        n_total++; if (pix_valid !== 1'b0) $display("FAIL bp_valid_drop got %0b want 0", pix_valid); else n_pass++;
        wait_sig(0, 200, n);
        n_total++; if (pix_data !== 24'h554466) $display("FAIL bp_next_data got %h want 554466", pix_data); else n_pass++;
        n_total++; if (ledindex !== 8'd1) $display("FAIL bp_next_idx got %0d want 1", ledindex); else n_pass++;
        pix_ready = 1'b1;
        wait_sig(1, LC + 100, n);
        tick();
        tick();
    endtask

    task automatic test_empty();
        int n;
        int x0;
        logic busy_ok;
        pix_ready = 1'b1;
        x0 = xfers;
        pulse_start(8'd0);
        busy_ok = busy;
        n = 0;
        while (frame_done !== 1'b1 && n < LC + 100) begin
            tick();
            n++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        n_total++; if (n !== LC - 1) $display("FAIL empty_latch got %0d want %0d", n, LC - 1); else n_pass++;
        n_total++; if (busy_ok !== 1'b1) $display("FAIL empty_busy got %0b want 1", busy_ok); else n_pass++;
        n_total++; if (xfers - x0 !== 0) $display("FAIL empty_xfers got %0d want 0", xfers - x0); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL empty_idle got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_ignored_start();
        int n;
        int x0;
        int f0;
        pix_ready = 1'b1;
        x0 = xfers; f0 = fd_count;
        pulse_start(8'd4);
        numleds = 8'd9;
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig(1, 4 * 65 + LC + 100, n);
        repeat (200) tick();
        n_total++; if (xfers - x0 !== 4) $display("FAIL ign_xfers got %0d want 4", xfers - x0); else n_pass++;
        n_total++; if (fd_count - f0 !== 1) $display("FAIL ign_fd got %0d want 1", fd_count - f0); else n_pass++;
        n_total++; if (last_idx !== 8'd3) $display("FAIL ign_last got %0d want 3", last_idx); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ign_idle got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int n;
        int f0;
        pix_ready = 1'b0;
        pulse_start(8'd3);
        wait_sig(0, 200, n);
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        wait_sig(0, 200, n);
        n_total++; if (ledindex !== 8'd1) $display("FAIL abort_pre_idx got %0d want 1", ledindex); else n_pass++;
        f0 = fd_count;
        rst = 1'b1; pix_ready = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; pix_ready = 1'b0; start = 1'b0;
        n_total++; if (pix_valid !== 1'b0) $display("FAIL abort_valid got %0b want 0", pix_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", busy); else n_pass++;
        n_total++; if (ledindex !== 8'd0) $display("FAIL abort_idx got %0d want 0", ledindex); else n_pass++;
        repeat (LC + 200) tick();
        n_total++; if (fd_count - f0 !== 0) $display("FAIL abort_no_fd got %0d want 0", fd_count - f0); else n_pass++;
        pix_ready = 1'b1;
        pulse_start(8'd3);
        wait_sig(0, 200, n);
        n_total++; if (n !== 64) $display("FAIL replay_lat got %0d want 64", n); else n_pass++;
        n_total++; if (ledindex !== 8'd0) $display("FAIL replay_idx got %0d want 0", ledindex); else n_pass++;
        wait_sig(1, 3 * 65 + LC + 100, n);
        tick();
        tick();
    endtask

    task automatic test_max_len();
        int n;
        int x0;
        int f0;
        int s0;
        pix_ready = 1'b1;
        x0 = xfers; f0 = fd_count; s0 = seq_err;
        pulse_start(8'd255);
        wait_sig(1, 255 * 65 + LC + 200, n);
        n_total++; if (n !== 255 * 65 - 1 + LC) $display("FAIL max_time got %0d want %0d", n, 255 * 65 - 1 + LC); else n_pass++;
        repeat (5) tick();
        n_total++; if (xfers - x0 !== 255) $display("FAIL max_xfers got %0d want 255", xfers - x0); else n_pass++;
        n_total++; if (last_idx !== 8'd254) $display("FAIL max_last got %0d want 254", last_idx); else n_pass++;
        n_total++; if (seq_err - s0 !== 0) $display("FAIL max_seq got %0d want 0", seq_err - s0); else n_pass++;
        n_total++; if (ledindex !== 8'd254) $display("FAIL max_hold_idx got %0d want 254", ledindex); else n_pass++;
        n_total++; if (fd_count - f0 !== 1) $display("FAIL max_fd got %0d want 1", fd_count - f0); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; numleds = 8'd0; pix_ready = 1'b0;
        red = 8'd0; green = 8'd0; blue = 8'd0;
        tick();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_empty();
        test_ignored_start();
        test_reset_abort();
        test_max_len();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
